serial_transmitting: RTL and testbench
======================================

# serial_transmitting

Serial transmitter feeding the `receiving` block's `data_in` line. Accepts a 7-bit character over a load/ready handshake and serialises it as a 10-bit frame: start bit, 7 data bits LSB first, even parity bit, stop bit. Each bit is held for 16 clocks so the receiver's 16x oversampling sees it. A one-character holding register lets the next character be queued during a frame, so frames go out back-to-back with no idle gap.

## Interface
- `CLKS_PER_BIT`, 16, clocks per serial bit; power of two, ≥ 2.
- `DATA_BITS`, 7, data bits per frame. Frame width is `DATA_BITS+3` = 10.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high; sampled on `clk` rising edge.
- `load`  input  1  request to queue `char_in`; honoured only while `ready`=1.
- `char_in`  input  7  character to send; sampled in the cycle `load`=1 and `ready`=1.
- `data_out`  output  1  serial line, idle high; connects to the receiver's `data_in`.
- `ready`  output  1  holding register empty, so a load is accepted this cycle.
- `busy`  output  1  a frame is on the line (any state other than IDLE).
- `charSent`  output  1  one-cycle pulse in the last clock of each stop bit.
- `overrun`  output  1  one-cycle pulse, registered, the cycle after a `load` is dropped because `ready`=0.

## Operation
- Reset values: `data_out`=1, `ready`=1, `busy`=0, `charSent`=0, `overrun`=0. On reset, state goes to IDLE, the holding register is emptied and both counters are cleared. Reset wins over every other event.
- Reset mid-frame aborts the frame immediately: `data_out`=1 from the next cycle. No `charSent` pulse is generated for the aborted frame.
- Accepting a load: `load`=1 with `ready`=1 latches `char_in` into the holding register and sets `ready`=0.
- Dropping a load: `load`=1 with `ready`=0 is ignored, the held data is unchanged, and `overrun` pulses.
- States: IDLE → START → DATA → PARITY → STOP.
  - IDLE: when the holding register is full, move its contents to the shift register, compute parity, empty the holding register (`ready`=1), go to START.
  - START: line 0 for `CLKS_PER_BIT` clocks → DATA.
  - DATA: bit i = `char_in[i]`, i = 0..6, each for `CLKS_PER_BIT` clocks → PARITY after bit 6.
  - PARITY: line = XOR of the 7 data bits (even parity over data + parity) → STOP.
  - STOP: line 1 for `CLKS_PER_BIT` clocks, `charSent` pulses in the last one. If the holding register is full, reload and go straight to START with no idle cycle; otherwise go to IDLE.
- Load and dequeue in the same cycle: when `load` arrives in the same cycle the holding register is emptied, `ready` is still 0 that cycle, so the load is dropped and `overrun` pulses. Upstream must wait for `ready`=1.
- Counters: a baud counter of width log2(`CLKS_PER_BIT`) wraps to 0 at `CLKS_PER_BIT`-1 and advances the bit. A 3-bit bit index counts 0..6.

## Timing
- `load` accepted in cycle t while IDLE → `ready` low in t+1, high again in t+2 (dequeued). `data_out` falls to 0 in t+2.
- Frame length is exactly 10·`CLKS_PER_BIT` = 160 clocks. `charSent` is high in cycle t+161. With nothing queued, `busy`=0 from t+162.
- Back-to-back frames: the next start bit begins in the clock right after the stop bit's last clock, giving a continuous 160-clock cadence.
- All outputs are registered; no combinational path from an input to an output.

## Structure
- Shared package `serial_pkg`:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - `FRAME_BITS`=10;
  - `CLKS_PER_BIT`=16, reused by the receiver;
  - `START_BIT`=0, `STOP_BIT`=1.
- Sub-module `baud_counter`: parameterised by `CLKS_PER_BIT`; inputs `clk`, `reset`, `clear`; output `bit_done` pulse. Intended for later reuse on the receiver side.

## Test plan
- Reset: hold `reset` 2 cycles → `data_out`=1, `ready`=1, `busy`=0, no pulses for 50 idle cycles.
- Single character 7'h4B → line sequence 0,1,1,0,1,0,0,1,0,1, each bit exactly 16 clocks; `charSent` pulses once at t+161. A loopback to `receiving` yields `data_out`=10'b1010010110 (frame bits in order received) and `charReceived`.
- 7'h0D → parity bit 1; line sequence 0,1,0,1,1,0,0,0,1,1.
- Queue 7'h4B, then 7'h0D as soon as `ready` returns → the two frames are contiguous (320 clocks, no idle gap), with `charSent` pulses 160 clocks apart.
- Load while `ready`=0 (during frame 1 with 7'h0D already queued) → `overrun` pulses once and frame 2 still carries 7'h0D.
- Assert `reset` in the 5th data bit → `data_out`=1 the next cycle, no `charSent`. A fresh load afterwards produces a clean full frame.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit/receive pair: frame geometry,
// line levels and FSM state encoding.
package serial_pkg;

    localparam int CLKS_PER_BIT = 16;
    localparam int FRAME_BITS   = 10;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = S_IDLE,
        START  = S_START,
        DATA   = S_DATA,
        PARITY = S_PARITY,
        STOP   = S_STOP
    } state_t;

endpackage

// File: rtl/serial_transmitting_baud_counter.sv
// Bit-period timer: counts clocks within one serial bit and flags the last
// clock (bit_done) and the one before it (bit_almost_done).
module baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done,
    output logic bit_almost_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign bit_done        = (count_reg == LAST);
    assign bit_almost_done = (count_reg == PRE);

endmodule

// File: rtl/serial_transmitting.sv
// Serial transmitter: start bit, DATA_BITS data bits LSB first, even parity,
// stop bit. A one-deep holding register allows back-to-back frames.
module serial_transmitting #(
    parameter int CLKS_PER_BIT = serial_pkg::CLKS_PER_BIT,
    parameter int DATA_BITS    = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] char_in,
    output logic                 data_out,
    output logic                 ready,
    output logic                 busy,
    output logic                 charSent,
    output logic                 overrun
);
    import serial_pkg::*;

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    state_t               state_reg, state_next;
    logic [DATA_BITS-1:0] hold_reg;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic                 parity_reg, parity_next;
    logic                 line_reg, line_next;
    logic                 ready_reg;
    logic                 busy_reg;
    logic                 char_sent_reg;
    logic                 overrun_reg;
    logic                 dequeue;
    logic                 baud_clear;
    logic                 bit_done;
    logic                 bit_almost_done;

    // Holding the counter at zero while idle makes the start bit last a full period.
    assign baud_clear = (state_reg == IDLE);

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk            (clk),
        .reset          (reset),
        .clear          (baud_clear),
        .bit_done       (bit_done),
        .bit_almost_done(bit_almost_done)
    );

    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        idx_next    = idx_reg;
        parity_next = parity_reg;
        line_next   = line_reg;
        dequeue     = 1'b0;
        case (state_reg)
            IDLE: begin
                line_next = STOP_BIT;
                if (!ready_reg) begin
                    dequeue     = 1'b1;
                    state_next  = START;
                    shift_next  = hold_reg;
                    parity_next = ^hold_reg;
                    line_next   = START_BIT;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                    idx_next   = '0;
                    line_next  = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = PARITY;
                        line_next  = parity_reg;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        shift_next = shift_reg >> 1;
                        line_next  = shift_reg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                    line_next  = STOP_BIT;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (!ready_reg) begin
                        // Queued character: start bit follows with no idle clock.
                        dequeue     = 1'b1;
                        state_next  = START;
                        shift_next  = hold_reg;
                        parity_next = ^hold_reg;
                        line_next   = START_BIT;
                    end else begin
                        state_next = IDLE;
                        line_next  = STOP_BIT;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                line_next  = STOP_BIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            hold_reg      <= '0;
            shift_reg     <= '0;
            idx_reg       <= '0;
            parity_reg    <= 1'b0;
            line_reg      <= STOP_BIT;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b0;
            char_sent_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            idx_reg    <= idx_next;
            parity_reg <= parity_next;
            line_reg   <= line_next;
            busy_reg   <= (state_next != IDLE);
            // Loads and dequeues are exclusive: one needs ready high, the other low.
            if (load && ready_reg) begin
                hold_reg  <= char_in;
                ready_reg <= 1'b0;
            end else if (dequeue) begin
                ready_reg <= 1'b1;
            end
            overrun_reg   <= load && !ready_reg;
            char_sent_reg <= (state_reg == STOP) && bit_almost_done;
        end
    end

    assign data_out = line_reg;
    assign ready    = ready_reg;
    assign busy     = busy_reg;
    assign charSent = char_sent_reg;
    assign overrun  = overrun_reg;

endmodule

// File: tb/tb_serial_transmitting.sv
// Self-checking bench for serial_transmitting: per-scenario tasks plus a line
// monitor that checks every frame against a queue of expected characters.
module tb_serial_transmitting;

    localparam int CPB = 16;
    localparam int FRAME_CLKS = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [6:0] char_in = '0;
    logic       data_out, ready, busy, charSent, overrun;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int sent_cnt = 0;
    int overrun_cnt = 0;

    logic [6:0] char_q[$];
    int         frame_starts[$];
    int         sent_cycles[$];

    serial_transmitting #(.CLKS_PER_BIT(CPB), .DATA_BITS(7)) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .char_in (char_in),
        .data_out(data_out),
        .ready   (ready),
        .busy    (busy),
        .charSent(charSent),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [9:0] build_frame(input logic [6:0] c);
        logic [9:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 7; i++) f[1+i] = c[i];
        f[8] = ^c;
        f[9] = 1'b1;
        return f;
    endfunction

    // Line monitor / scoreboard consumer
    logic       mon_active = 1'b0;
    logic       mon_glitch = 1'b0;
    logic       mon_unexp = 1'b0;
    logic       prev_line = 1'bx;
    logic [9:0] mon_exp = '0;
    logic [9:0] mon_got = '0;
    logic [6:0] mon_char = '0;
    int         mon_cyc = 0;

    always @(negedge clk) begin
        logic end_now;
        int   k;
        end_now = mon_active && (mon_cyc == FRAME_CLKS - 1);
        if (overrun === 1'b1) overrun_cnt++;
        if (reset === 1'b1) begin
            if (mon_active) begin
                mon_active = 1'b0;
                if (char_q.size() > 0) void'(char_q.pop_front());
            end
        end else begin
            if (charSent === 1'b1) begin
                sent_cnt++;
                sent_cycles.push_back(cycle);
                if (!end_now) begin
                    tests++;
                    fails++;
                    $display("FAIL charsent_spurious: pulse at cycle %0d, required only in last stop clock", cycle);
                end
            end
            if (!mon_active && data_out === 1'b0 && prev_line === 1'b1) begin
                mon_active = 1'b1;
                mon_cyc    = 0;
                mon_glitch = 1'b0;
                mon_got    = '0;
                frame_starts.push_back(cycle);
                if (char_q.size() == 0) begin
                    mon_unexp = 1'b1;
                    mon_exp   = '1;
                end else begin
                    mon_unexp = 1'b0;
                    mon_char  = char_q.pop_front();
                    mon_exp   = build_frame(mon_char);
                end
            end
            if (mon_active) begin
                k = mon_cyc / CPB;
                if (data_out !== mon_exp[k]) mon_glitch = 1'b1;
                if ((mon_cyc % CPB) == CPB / 2) mon_got[k] = data_out;
                if (mon_cyc == FRAME_CLKS - 1) begin
                    tests++;
                    if (mon_unexp || mon_glitch || mon_got !== mon_exp || charSent !== 1'b1) begin
                        fails++;
                        $display("FAIL frame: char %h got bits %b (unexpected=%0b unstable=%0b charSent=%b), required %b with charSent=1",
                                 mon_char, mon_got, mon_unexp, mon_glitch, charSent, mon_exp);
                    end
                    mon_active = 1'b0;
                end else begin
                    mon_cyc++;
                end
            end
        end
        prev_line = data_out;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 400) begin
            next_cycle();
            n++;
        end
        if (n == 400) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: ready=%b after 400 cycles, required 1", ready);
        end
    endtask

    // Drives one accepted load in the current cycle; returns in the following cycle.
    task automatic send_char(input logic [6:0] c);
        wait_ready();
        load    = 1'b1;
        char_in = c;
        char_q.push_back(c);
        next_cycle();
        load    = 1'b0;
        char_in = '0;
    endtask

    task automatic test_reset();
        logic bad = 1'b0;
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        tests++; if (data_out !== 1'b1) begin fails++; $display("FAIL reset_data_out: got %b, required 1", data_out); end
        tests++; if (ready !== 1'b1)    begin fails++; $display("FAIL reset_ready: got %b, required 1", ready); end
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
        tests++; if (charSent !== 1'b0) begin fails++; $display("FAIL reset_charsent: got %b, required 0", charSent); end
        tests++; if (overrun !== 1'b0)  begin fails++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
        for (int i = 0; i < 50; i++) begin
            next_cycle();
            if (data_out !== 1'b1 || busy !== 1'b0 || charSent !== 1'b0 || overrun !== 1'b0 || ready !== 1'b1) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL reset_idle: outputs changed during 50 idle cycles, required line=1 ready=1 no pulses");
        end
    endtask

    task automatic test_single(input logic [6:0] c);
        send_char(c);
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL single_%h_ready_t1: got %b, required 0", c, ready); end
        next_cycle();
        tests++;
        if (ready !== 1'b1 || data_out !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_%h_t2: ready=%b data_out=%b busy=%b, required 1 0 1", c, ready, data_out, busy);
        end
        for (int i = 0; i < 159; i++) next_cycle();
        tests++; if (charSent !== 1'b1) begin fails++; $display("FAIL single_%h_charsent_t161: got %b, required 1", c, charSent); end
        next_cycle();
        tests++;
        if (busy !== 1'b0 || charSent !== 1'b0 || data_out !== 1'b1) begin
            fails++;
            $display("FAIL single_%h_t162: busy=%b charSent=%b data_out=%b, required 0 0 1", c, busy, charSent, data_out);
        end
    endtask

    task automatic test_back_to_back();
        int fs0 = frame_starts.size();
        int sc0 = sent_cycles.size();
        int ov0 = overrun_cnt;
        send_char(7'h4B);
        send_char(7'h0D);
        for (int i = 0; i < 20; i++) next_cycle();
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_full: got %b, required 0", ready); end
        load    = 1'b1;
        char_in = 7'h55;
        next_cycle();
        load    = 1'b0;
        char_in = '0;
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_pulse: got %b, required 1", overrun); end
        next_cycle();
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_width: got %b, required 0", overrun); end
        for (int i = 0; i < 320; i++) next_cycle();
        tests++;
        if (frame_starts.size() != fs0 + 2 || sent_cycles.size() != sc0 + 2) begin
            fails++;
            $display("FAIL b2b_count: frames %0d pulses %0d, required 2 and 2",
                     frame_starts.size() - fs0, sent_cycles.size() - sc0);
        end else begin
            tests++;
            if (frame_starts[fs0+1] - frame_starts[fs0] != FRAME_CLKS) begin
                fails++;
                $display("FAIL b2b_frame_gap: got %0d clocks, required %0d", frame_starts[fs0+1] - frame_starts[fs0], FRAME_CLKS);
            end
            tests++;
            if (sent_cycles[sc0+1] - sent_cycles[sc0] != FRAME_CLKS) begin
                fails++;
                $display("FAIL b2b_charsent_gap: got %0d clocks, required %0d", sent_cycles[sc0+1] - sent_cycles[sc0], FRAME_CLKS);
            end
        end
        tests++; if (overrun_cnt - ov0 != 1) begin fails++; $display("FAIL overrun_count: got %0d, required 1", overrun_cnt - ov0); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_busy: got %b, required 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        int sc0;
        send_char(7'h4B);
        for (int i = 0; i < 88; i++) next_cycle();
        sc0   = sent_cnt;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        tests++;
        if (data_out !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
            fails++;
            $display("FAIL abort_outputs: data_out=%b busy=%b ready=%b, required 1 0 1", data_out, busy, ready);
        end
        for (int i = 0; i < 200; i++) next_cycle();
        tests++; if (sent_cnt != sc0) begin fails++; $display("FAIL abort_charsent: got %0d pulses, required 0", sent_cnt - sc0); end
        test_single(7'h4B);
    endtask

    initial begin
        test_reset();
        test_single(7'h4B);
        test_single(7'h0D);
        test_back_to_back();
        test_reset_mid_frame();
        for (int i = 0; i < 5; i++) next_cycle();
        tests++; if (char_q.size() != 0) begin fails++; $display("FAIL scoreboard_empty: %0d left, required 0", char_q.size()); end
        tests++; if (sent_cnt != 5) begin fails++; $display("FAIL charsent_total: got %0d, required 5", sent_cnt); end
        tests++; if (overrun_cnt != 1) begin fails++; $display("FAIL overrun_total: got %0d, required 1", overrun_cnt); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
